cc_writeback_sequencer: RTL and testbench
=========================================

Name: cc_writeback_sequencer

Overview:
Sequences register-file write-back for the microcoded datapath. It accepts a write request from the control unit and selects the destination from the MIR field or the scratchpad field. It selects the source as ALU result or main-memory data, handshaking with memory when needed. It then issues one active-low load pulse to registers r2..r15, and also sequences a global register clear.

Parameters:
DATAWIDTH_BUS, 32, data bus width
DATAWIDTH_DECODER_OUT, 14, number of writable registers (r2..r15)
DATAWIDTH_MIR_SELECTION, 6, MIR destination field width
DATAWIDTH_SCRATCHPAD_SELECTION, 5, scratchpad destination field width
REG_BASE, 2, address of first writable register (load bit 0)
TIMEOUT_CYCLES, 15, max WAIT_MEM cycles (used only with timeout feature)
TIMEOUT_WIDTH, 4, timeout counter width

Ports:
CC_WBSEQ_CLOCK_50  in  1  system clock, rising edge
CC_WBSEQ_RESET_InHigh  in  1  synchronous active-high reset
CC_WBSEQ_Req_In  in  1  write request, level, held until Ack
CC_WBSEQ_Clear_In  in  1  clear-all request, level, held until Ack
CC_WBSEQ_RD_In  in  1  source: 1=memory, 0=ALU
CC_WBSEQ_Select_In  in  1  destination: 1=MIR field, 0=scratchpad field
CC_WBSEQ_MIRSelection_InBus  in  DATAWIDTH_MIR_SELECTION  MIR destination
CC_WBSEQ_ScratchpadSelection_InBus  in  DATAWIDTH_SCRATCHPAD_SELECTION  scratchpad destination, zero-extended
CC_WBSEQ_ALU_data_InBus  in  DATAWIDTH_BUS  ALU result
CC_WBSEQ_Memory_data_InBus  in  DATAWIDTH_BUS  memory read data
CC_WBSEQ_MemReady_In  in  1  memory data valid
CC_WBSEQ_MemRead_Out  out  1  memory read strobe
CC_WBSEQ_data_OutBus  out  DATAWIDTH_BUS  write-back data
CC_WBSEQ_Load_OutBus  out  DATAWIDTH_DECODER_OUT  per-register load, active-low
CC_WBSEQ_Clear_OutBus  out  DATAWIDTH_DECODER_OUT  per-register clear, active-low
CC_WBSEQ_Ack_Out  out  1  request accepted, 1-cycle pulse
CC_WBSEQ_Busy_Out  out  1  operation in progress
CC_WBSEQ_Done_Out  out  1  operation finished, 1-cycle pulse
CC_WBSEQ_Error_Out  out  1  qualifies Done: write dropped

Behaviour:
- Single clock domain. Reset is synchronous and active-high: CC_WBSEQ_RESET_InHigh=1 at a rising edge of CC_WBSEQ_CLOCK_50 forces the reset state.
- Reset values: state IDLE, data_OutBus=0, Load=all 1s, Clear=all 1s, MemRead=0, Ack=0, Busy=0, Done=0, Error=0, timeout counter=0.
- Reset mid-operation returns to IDLE on that edge. No pending load or clear pulse is issued.
- All outputs are driven from flops (glitch-free). Load and Clear are never both active in the same cycle.
- FSM states: IDLE, WAIT_MEM, WRITE, CLEAR, DONE.
- IDLE, Clear_In=1: Ack=1 for 1 cycle, then go to CLEAR. Clear has priority over Req; a simultaneous Req is not acked.
- IDLE, Req_In=1 and Clear_In=0: Ack=1 for 1 cycle. Latch these:
  - addr = Select_In ? MIR : {0,scratchpad}
  - src = RD_In
  - ALU data, latched into data_OutBus if RD_In=0
  Next state is WAIT_MEM if RD_In=1, else WRITE.
- WAIT_MEM: MemRead=1. On MemReady_In=1, latch Memory_data into data_OutBus and go to WRITE; MemRead drops in that next cycle.
- WRITE, 1 cycle: if REG_BASE <= addr <= REG_BASE+13, Load bit (addr-REG_BASE)=0 and all other bits=1. Otherwise Load stays all 1s and an error flag is set. Then go to DONE.
- CLEAR, 1 cycle: Clear=all 0s, then go to DONE.
- DONE, 1 cycle: Done=1, and Error=error flag. Then go to IDLE and clear the error flag.
- Busy=1 in every state except IDLE.
- data_OutBus holds its last value outside WRITE.
- ALU-path latency: Req seen at edge N. Ack high in cycle N+1 (first WRITE cycle, Load pulse). Done in cycle N+2. IDLE in cycle N+3, when a new Req may be accepted.
- Memory path: WRITE follows 1 cycle after the MemReady edge.
- Input changes after Ack do not affect the operation in flight.

Optional Feature:
- Macro: CC_WBSEQ_MEM_TIMEOUT_EN.
- Defined: the counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle with MemReady=0. When the count reaches TIMEOUT_CYCLES: MemRead drops, go to DONE with Error=1, and issue no Load pulse.
- Not defined: no counter logic; WAIT_MEM waits indefinitely for MemReady.

Test Plan:
- Reset held 2 cycles, then released -> Load=14'h3FFF, Clear=14'h3FFF, Busy=0, Done=0, data_OutBus=0.
- Req=1, RD=0, Select=1, MIR=6'd5, ALU=32'hDEADBEEF -> Ack at N+1; Load=14'b11111111110111 for exactly 1 cycle with data_OutBus=32'hDEADBEEF; Done at N+2, Error=0.
- Req=1, RD=1, Select=0, scratchpad=5'd15; MemReady high after 3 cycles with mem=32'h12345678 -> MemRead high 3 cycles; Load=14'b01111111111111 with data 32'h12345678; Done next cycle.
- Req=1, RD=0, MIR=6'd1 (and separately 6'd20) -> Load stays 14'h3FFF throughout; Done=1 with Error=1.
- Req=1 and Clear=1 in the same IDLE cycle -> Clear=14'h0000 for 1 cycle, no Load pulse; Req acked only after returning to IDLE.
- Reset asserted in WAIT_MEM -> IDLE next edge, MemRead=0, no Load pulse. With CC_WBSEQ_MEM_TIMEOUT_EN and MemReady held 0 -> Done+Error after 15 WAIT_MEM cycles, no Load.

Source files
------------

// File: rtl/cc_writeback_sequencer.sv
// ---------------------------------------------------------------------------
// cc_writeback_sequencer
//
// Purpose:
//   Sequences register-file write-back for the microcoded datapath. A write
//   request picks its destination from the MIR field or the zero-extended
//   scratchpad field. It picks its source from the ALU result or from main
//   memory, using a read handshake for memory. It then drives one active-low
//   load pulse to the addressed register (r2..r15). A clear-all request
//   drives one active-low clear pulse to every register instead.
//
//   Optional build macro: CC_WBSEQ_MEM_TIMEOUT_EN
//     When defined, a memory wait that sees no MemReady for TIMEOUT_CYCLES
//     cycles is abandoned. The operation then finishes with Error=1 and
//     issues no load pulse. When undefined, the memory wait has no limit.
//
// Ports:
//   CC_WBSEQ_CLOCK_50                  in   system clock, rising edge
//   CC_WBSEQ_RESET_InHigh              in   synchronous active-high reset
//   CC_WBSEQ_Req_In                    in   write request (level, held until Ack)
//   CC_WBSEQ_Clear_In                  in   clear-all request (level, held until Ack)
//   CC_WBSEQ_RD_In                     in   source: 1=memory, 0=ALU
//   CC_WBSEQ_Select_In                 in   destination: 1=MIR, 0=scratchpad
//   CC_WBSEQ_MIRSelection_InBus        in   MIR destination field
//   CC_WBSEQ_ScratchpadSelection_InBus in   scratchpad destination field
//   CC_WBSEQ_ALU_data_InBus            in   ALU result
//   CC_WBSEQ_Memory_data_InBus         in   memory read data
//   CC_WBSEQ_MemReady_In               in   memory data valid
//   CC_WBSEQ_MemRead_Out               out  memory read strobe
//   CC_WBSEQ_data_OutBus               out  write-back data
//   CC_WBSEQ_Load_OutBus               out  per-register load, active-low
//   CC_WBSEQ_Clear_OutBus              out  per-register clear, active-low
//   CC_WBSEQ_Ack_Out                   out  request accepted, 1-cycle pulse
//   CC_WBSEQ_Busy_Out                  out  operation in progress
//   CC_WBSEQ_Done_Out                  out  operation finished, 1-cycle pulse
//   CC_WBSEQ_Error_Out                 out  qualifies Done: write dropped
// ---------------------------------------------------------------------------
module cc_writeback_sequencer #(
   parameter int DATAWIDTH_BUS                  = 32,
   parameter int DATAWIDTH_DECODER_OUT          = 14,
   parameter int DATAWIDTH_MIR_SELECTION        = 6,
   parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5,
   parameter int REG_BASE                       = 2,
   parameter int TIMEOUT_CYCLES                 = 15,
   parameter int TIMEOUT_WIDTH                  = 4
) (
   input  logic                                      CC_WBSEQ_CLOCK_50,
   input  logic                                      CC_WBSEQ_RESET_InHigh,
   input  logic                                      CC_WBSEQ_Req_In,
   input  logic                                      CC_WBSEQ_Clear_In,
   input  logic                                      CC_WBSEQ_RD_In,
   input  logic                                      CC_WBSEQ_Select_In,
   input  logic [DATAWIDTH_MIR_SELECTION-1:0]        CC_WBSEQ_MIRSelection_InBus,
   input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0] CC_WBSEQ_ScratchpadSelection_InBus,
   input  logic [DATAWIDTH_BUS-1:0]                  CC_WBSEQ_ALU_data_InBus,
   input  logic [DATAWIDTH_BUS-1:0]                  CC_WBSEQ_Memory_data_InBus,
   input  logic                                      CC_WBSEQ_MemReady_In,
   output logic                                      CC_WBSEQ_MemRead_Out,
   output logic [DATAWIDTH_BUS-1:0]                  CC_WBSEQ_data_OutBus,
   output logic [DATAWIDTH_DECODER_OUT-1:0]          CC_WBSEQ_Load_OutBus,
   output logic [DATAWIDTH_DECODER_OUT-1:0]          CC_WBSEQ_Clear_OutBus,
   output logic                                      CC_WBSEQ_Ack_Out,
   output logic                                      CC_WBSEQ_Busy_Out,
   output logic                                      CC_WBSEQ_Done_Out,
   output logic                                      CC_WBSEQ_Error_Out
);

   // The MIR field is the wider destination field. The scratchpad field is
   // zero-extended to this width.
   localparam int ADDR_W = DATAWIDTH_MIR_SELECTION;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_MEM = 3'd1;
   localparam logic [2:0] ST_WRITE    = 3'd2;
   localparam logic [2:0] ST_CLEAR    = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   logic [2:0]                     state;
   logic [2:0]                     state_nxt;
   logic [ADDR_W-1:0]              addr;
   logic [ADDR_W-1:0]              addr_nxt;
   logic                           err;
   logic                           err_nxt;
   logic                           ack_nxt;
   logic [DATAWIDTH_BUS-1:0]       data_nxt;

`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0]       tmo_cnt;
   logic [TIMEOUT_WIDTH-1:0]       tmo_cnt_nxt;
   logic [TIMEOUT_WIDTH-1:0]       tmo_cnt_inc;
   assign tmo_cnt_inc = tmo_cnt + 1'b1;
`endif

   // True when the address names one of the writable registers.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return (int'(a) >= REG_BASE) && (int'(a) <= REG_BASE + DATAWIDTH_DECODER_OUT - 1);
   endfunction

   // One-cold decode of the destination. An address outside the writable
   // window matches no bit, so the result stays all ones.
   function automatic logic [DATAWIDTH_DECODER_OUT-1:0] load_decode(input logic [ADDR_W-1:0] a);
      logic [DATAWIDTH_DECODER_OUT-1:0] v;
      v = '1;
      for (int i = 0; i < DATAWIDTH_DECODER_OUT; i++) begin
         if (int'(a) == REG_BASE + i) v[i] = 1'b0;
      end
      return v;
   endfunction

   // Next-state and operand capture
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      err_nxt   = err;
      ack_nxt   = 1'b0;
      data_nxt  = CC_WBSEQ_data_OutBus;
`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
      tmo_cnt_nxt = tmo_cnt;
`endif
      case (state)
         ST_IDLE: begin
            // Clear wins over a simultaneous write request. The request stays
            // un-acked and is picked up once the sequencer is idle again.
            if (CC_WBSEQ_Clear_In) begin
               ack_nxt   = 1'b1;
               err_nxt   = 1'b0;
               state_nxt = ST_CLEAR;
            end else if (CC_WBSEQ_Req_In) begin
               ack_nxt  = 1'b1;
               addr_nxt = CC_WBSEQ_Select_In ? CC_WBSEQ_MIRSelection_InBus
                                             : ADDR_W'(CC_WBSEQ_ScratchpadSelection_InBus);
               if (CC_WBSEQ_RD_In) begin
                  state_nxt = ST_WAIT_MEM;
`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
                  tmo_cnt_nxt = '0;
`endif
               end else begin
                  data_nxt  = CC_WBSEQ_ALU_data_InBus;
                  err_nxt   = !addr_in_range(addr_nxt);
                  state_nxt = ST_WRITE;
               end
            end
         end
         ST_WAIT_MEM: begin
            if (CC_WBSEQ_MemReady_In) begin
               data_nxt  = CC_WBSEQ_Memory_data_InBus;
               err_nxt   = !addr_in_range(addr);
               state_nxt = ST_WRITE;
            end
`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
            else if (int'(tmo_cnt_inc) == TIMEOUT_CYCLES) begin
               // Give up on memory: report the drop and skip the write.
               tmo_cnt_nxt = tmo_cnt_inc;
               err_nxt     = 1'b1;
               state_nxt   = ST_DONE;
            end else begin
               tmo_cnt_nxt = tmo_cnt_inc;
            end
`endif
         end
         ST_WRITE: state_nxt = ST_DONE;
         ST_CLEAR: state_nxt = ST_DONE;
         ST_DONE: begin
            err_nxt   = 1'b0;
            state_nxt = ST_IDLE;
         end
         default: begin
            err_nxt   = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered outputs are decoded from the state being entered. Every
   // output therefore comes from a flop and lines up with its state. For
   // example, Ack and the ALU-path load pulse appear in the same cycle.
   always_ff @(posedge CC_WBSEQ_CLOCK_50) begin
      if (CC_WBSEQ_RESET_InHigh) begin
         state                 <= ST_IDLE;
         err                   <= 1'b0;
         CC_WBSEQ_data_OutBus  <= '0;
         CC_WBSEQ_Load_OutBus  <= '1;
         CC_WBSEQ_Clear_OutBus <= '1;
         CC_WBSEQ_MemRead_Out  <= 1'b0;
         CC_WBSEQ_Ack_Out      <= 1'b0;
         CC_WBSEQ_Busy_Out     <= 1'b0;
         CC_WBSEQ_Done_Out     <= 1'b0;
         CC_WBSEQ_Error_Out    <= 1'b0;
`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
         tmo_cnt               <= '0;
`endif
      end else begin
         state                 <= state_nxt;
         err                   <= err_nxt;
         CC_WBSEQ_data_OutBus  <= data_nxt;
         CC_WBSEQ_Load_OutBus  <= (state_nxt == ST_WRITE) ? load_decode(addr_nxt) : '1;
         CC_WBSEQ_Clear_OutBus <= (state_nxt == ST_CLEAR) ? '0 : '1;
         CC_WBSEQ_MemRead_Out  <= (state_nxt == ST_WAIT_MEM);
         CC_WBSEQ_Ack_Out      <= ack_nxt;
         CC_WBSEQ_Busy_Out     <= (state_nxt != ST_IDLE);
         CC_WBSEQ_Done_Out     <= (state_nxt == ST_DONE);
         CC_WBSEQ_Error_Out    <= (state_nxt == ST_DONE) && err_nxt;
`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
         tmo_cnt               <= tmo_cnt_nxt;
`endif
      end
   end

   // Destination register. It only matters while an operation is in flight,
   // so it carries no reset.
   always_ff @(posedge CC_WBSEQ_CLOCK_50) begin
      addr <= addr_nxt;
   end

endmodule

// File: tb/tb_cc_writeback_sequencer.sv
module tb_cc_writeback_sequencer;

   logic        clk;
   logic        rst;
   logic        req;
   logic        clr;
   logic        rd;
   logic        sel;
   logic [5:0]  mir;
   logic [4:0]  sp;
   logic [31:0] alu;
   logic [31:0] mem;
   logic        mem_ready;
   logic        mem_read;
   logic [31:0] data;
   logic [13:0] load;
   logic [13:0] clear;
   logic        ack;
   logic        busy;
   logic        done;
   logic        error;

   int vectors;
   int miscompares;

   cc_writeback_sequencer dut (
      .CC_WBSEQ_CLOCK_50                  (clk),
      .CC_WBSEQ_RESET_InHigh              (rst),
      .CC_WBSEQ_Req_In                    (req),
      .CC_WBSEQ_Clear_In                  (clr),
      .CC_WBSEQ_RD_In                     (rd),
      .CC_WBSEQ_Select_In                 (sel),
      .CC_WBSEQ_MIRSelection_InBus        (mir),
      .CC_WBSEQ_ScratchpadSelection_InBus (sp),
      .CC_WBSEQ_ALU_data_InBus            (alu),
      .CC_WBSEQ_Memory_data_InBus         (mem),
      .CC_WBSEQ_MemReady_In               (mem_ready),
      .CC_WBSEQ_MemRead_Out               (mem_read),
      .CC_WBSEQ_data_OutBus               (data),
      .CC_WBSEQ_Load_OutBus               (load),
      .CC_WBSEQ_Clear_OutBus              (clear),
      .CC_WBSEQ_Ack_Out                   (ack),
      .CC_WBSEQ_Busy_Out                  (busy),
      .CC_WBSEQ_Done_Out                  (done),
      .CC_WBSEQ_Error_Out                 (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic [5:0]  mir;
      logic [4:0]  sp;
      logic        rd;
      int          delay;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [13:0] exp_load;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: the active-low load pattern for a destination address.
   function automatic logic [13:0] model_load(input int addr);
      if (addr >= 2 && addr <= 15) return 14'h3FFF & ~(14'd1 << (addr - 2));
      return 14'h3FFF;
   endfunction

   // One complete write transaction, starting from IDLE.
   task automatic run_write(input logic s, input logic [5:0] m, input logic [4:0] p,
                            input logic r, input int delay, input logic [31:0] a,
                            input logic [31:0] md, input logic [13:0] exp_load,
                            input logic exp_err, input string tag);
      req = 1'b1; clr = 1'b0; sel = s; mir = m; sp = p; rd = r; alu = a;
      mem = ~md; mem_ready = 1'b0;
      step();
      check({tag, " ack"}, 32'(ack), 32'd1);
      check({tag, " busy"}, 32'(busy), 32'd1);
      // Scramble request-side inputs: the operation in flight must ignore them.
      req = 1'b0; sel = ~s; mir = m ^ 6'h2A; sp = p ^ 5'h15; rd = ~r; alu = ~a;
      if (r) begin
         check({tag, " memread"}, 32'(mem_read), 32'd1);
         check({tag, " load idle"}, 32'(load), 32'h3FFF);
         for (int i = 0; i < delay; i++) begin
            step();
            check({tag, " memread wait"}, 32'(mem_read), 32'd1);
         end
         mem_ready = 1'b1; mem = md;
         step();
         mem_ready = 1'b0; mem = ~md;
         check({tag, " memread drop"}, 32'(mem_read), 32'd0);
         check({tag, " ack low"}, 32'(ack), 32'd0);
      end
      check({tag, " load"}, 32'(load), 32'(exp_load));
      check({tag, " data"}, data, r ? md : a);
      check({tag, " clear"}, 32'(clear), 32'h3FFF);
      step();
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " error"}, 32'(error), 32'(exp_err));
      check({tag, " load after"}, 32'(load), 32'h3FFF);
      step();
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle done"}, 32'(done), 32'd0);
   endtask

   task automatic run_clear(input string tag);
      clr = 1'b1; req = 1'b0;
      step();
      check({tag, " ack"}, 32'(ack), 32'd1);
      check({tag, " clear"}, 32'(clear), 32'h0000);
      check({tag, " load"}, 32'(load), 32'h3FFF);
      clr = 1'b0;
      step();
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " error"}, 32'(error), 32'd0);
      check({tag, " clear after"}, 32'(clear), 32'h3FFF);
      step();
      check({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; req = 1'b0; clr = 1'b0; rd = 1'b0; sel = 1'b0; mir = '0; sp = '0;
      alu = '0; mem = '0; mem_ready = 1'b0;

      // sel, mir, sp, rd, delay, alu, mem, exp_load, exp_err
      vecs[0]  = '{1'b1, 6'd5,  5'd0,  1'b0, 0, 32'hDEADBEEF, 32'h0,        14'b11111111110111, 1'b0};
      vecs[1]  = '{1'b0, 6'd0,  5'd15, 1'b1, 2, 32'h0,        32'h12345678, 14'b01111111111111, 1'b0};
      vecs[2]  = '{1'b1, 6'd1,  5'd0,  1'b0, 0, 32'hA5A5A5A5, 32'h0,        14'h3FFF,           1'b1};
      vecs[3]  = '{1'b1, 6'd20, 5'd0,  1'b0, 0, 32'h5A5A5A5A, 32'h0,        14'h3FFF,           1'b1};
      vecs[4]  = '{1'b1, 6'd2,  5'd0,  1'b0, 0, 32'h00000001, 32'h0,        14'h3FFE,           1'b0};
      vecs[5]  = '{1'b1, 6'd15, 5'd0,  1'b0, 0, 32'h80000000, 32'h0,        14'h1FFF,           1'b0};
      vecs[6]  = '{1'b1, 6'd16, 5'd0,  1'b1, 0, 32'h0,        32'hCAFEF00D, 14'h3FFF,           1'b1};
      vecs[7]  = '{1'b0, 6'd0,  5'd2,  1'b1, 1, 32'h0,        32'h0BADC0DE, 14'h3FFE,           1'b0};
      vecs[8]  = '{1'b0, 6'd0,  5'd0,  1'b0, 0, 32'h11112222, 32'h0,        14'h3FFF,           1'b1};
      vecs[9]  = '{1'b0, 6'd0,  5'd9,  1'b0, 0, 32'h33334444, 32'h0,        14'h3F7F,           1'b0};
      vecs[10] = '{1'b1, 6'd10, 5'd0,  1'b1, 4, 32'h0,        32'hFFFFFFFF, 14'h3EFF,           1'b0};
      vecs[11] = '{1'b1, 6'd63, 5'd0,  1'b0, 0, 32'h76543210, 32'h0,        14'h3FFF,           1'b1};

      // Reset state
      step(); step();
      rst = 1'b0;
      step();
      check("reset load", 32'(load), 32'h3FFF);
      check("reset clear", 32'(clear), 32'h3FFF);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset data", data, 32'd0);
      check("reset memread", 32'(mem_read), 32'd0);
      check("reset ack", 32'(ack), 32'd0);

      // Table-driven transactions
      for (int i = 0; i < 12; i++) begin
         run_write(vecs[i].sel, vecs[i].mir, vecs[i].sp, vecs[i].rd, vecs[i].delay,
                   vecs[i].alu, vecs[i].mem, vecs[i].exp_load, vecs[i].exp_err,
                   $sformatf("vec%0d", i));
      end

      run_clear("clear");

      // Clear and Req together: clear first, the request waits for IDLE
      req = 1'b1; clr = 1'b1; sel = 1'b1; mir = 6'd7; rd = 1'b0; alu = 32'h01020304;
      step();
      check("both ack", 32'(ack), 32'd1);
      check("both clear", 32'(clear), 32'h0000);
      check("both load", 32'(load), 32'h3FFF);
      clr = 1'b0;
      step();
      check("both done", 32'(done), 32'd1);
      check("both no ack in done", 32'(ack), 32'd0);
      check("both no load in done", 32'(load), 32'h3FFF);
      step();
      check("both idle ack", 32'(ack), 32'd0);
      check("both idle busy", 32'(busy), 32'd0);
      check("both idle load", 32'(load), 32'h3FFF);
      step();
      check("both req ack", 32'(ack), 32'd1);
      check("both req load", 32'(load), 32'(model_load(7)));
      check("both req data", data, 32'h01020304);
      req = 1'b0;
      step(); step();
      check("both end", 32'(busy), 32'd0);

      // Reset during WAIT_MEM
      req = 1'b1; rd = 1'b1; sel = 1'b1; mir = 6'd4; mem_ready = 1'b0;
      step();
      req = 1'b0;
      step();
      check("rstmem memread before", 32'(mem_read), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstmem memread", 32'(mem_read), 32'd0);
      check("rstmem busy", 32'(busy), 32'd0);
      check("rstmem load", 32'(load), 32'h3FFF);
      check("rstmem data", data, 32'd0);
      mem_ready = 1'b1; mem = 32'h99999999;
      step();
      mem_ready = 1'b0;
      check("rstmem no pulse", 32'(load), 32'h3FFF);
      check("rstmem still idle", 32'(busy), 32'd0);

`ifdef CC_WBSEQ_MEM_TIMEOUT_EN
      // Memory never answers: Done with Error after 15 WAIT_MEM cycles
      req = 1'b1; rd = 1'b1; sel = 1'b1; mir = 6'd3; mem_ready = 1'b0;
      step();
      req = 1'b0;
      check("tmo memread first", 32'(mem_read), 32'd1);
      for (int i = 0; i < 14; i++) begin
         step();
         check("tmo memread", 32'(mem_read), 32'd1);
         check("tmo load", 32'(load), 32'h3FFF);
      end
      step();
      check("tmo done", 32'(done), 32'd1);
      check("tmo error", 32'(error), 32'd1);
      check("tmo memread drop", 32'(mem_read), 32'd0);
      check("tmo load", 32'(load), 32'h3FFF);
      step();
      check("tmo idle", 32'(busy), 32'd0);
`else
      // Without the timeout the memory wait is unbounded
      req = 1'b1; rd = 1'b1; sel = 1'b1; mir = 6'd3; mem_ready = 1'b0;
      step();
      req = 1'b0;
      for (int i = 0; i < 40; i++) step();
      check("wait memread", 32'(mem_read), 32'd1);
      check("wait no done", 32'(done), 32'd0);
      check("wait busy", 32'(busy), 32'd1);
      mem_ready = 1'b1; mem = 32'h55AA55AA;
      step();
      mem_ready = 1'b0;
      check("wait load", 32'(load), 32'(model_load(3)));
      check("wait data", data, 32'h55AA55AA);
      step();
      check("wait done", 32'(done), 32'd1);
      check("wait error", 32'(error), 32'd0);
      step();
`endif

      // Randomized transactions against the reference
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            run_clear($sformatf("rnd%0d clear", t));
         end else begin
            logic        s;
            logic [5:0]  m;
            logic [4:0]  p;
            logic        r;
            int          d;
            int          addr;
            logic [31:0] a;
            logic [31:0] md;
            s  = 1'($urandom_range(0, 1));
            m  = 6'($urandom_range(0, 22));
            p  = 5'($urandom_range(0, 31));
            r  = 1'($urandom_range(0, 1));
            d  = $urandom_range(0, 5);
            a  = $urandom;
            md = $urandom;
            addr = s ? int'(m) : int'(p);
            run_write(s, m, p, r, d, a, md, model_load(addr),
                      !(addr >= 2 && addr <= 15), $sformatf("rnd%0d", t));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
